// File: rtl/fifo_pkg.sv
// Shared constants for fifo_param: flag bit positions, error-bit indices and the
// occupancy-to-flag decode used by the top level.
package fifo_pkg;

  // Extra read-valid pipeline stages beyond the RAM's registered read port.
  localparam int RD_STAGES = 0;

  localparam int FLG_EMPTY = 0;
  localparam int FLG_FULL  = 1;
  localparam int FLG_AE    = 2;
  localparam int FLG_AF    = 3;
  localparam int FLG_PAUSA = 4;
  localparam int FLG_W     = 5;

  typedef enum logic {
    ERR_OVF = 1'b0,
    ERR_UNF = 1'b1
  } err_idx_e;

  localparam int ERR_W = 2;

  typedef struct packed {
    logic push;
    logic pop;
  } fifo_req_t;

  // Thresholds are compared in full integer width so an out-of-range af_th
  // (above depth) simply never matches instead of aliasing.
  function automatic logic [FLG_W-1:0] flag_decode(input int unsigned cnt,
                                                   input int unsigned depth,
                                                   input int unsigned af,
                                                   input int unsigned ae);
    logic [FLG_W-1:0] f;
    f            = '0;
    f[FLG_EMPTY] = (cnt == 0);
    f[FLG_FULL]  = (cnt == depth);
    f[FLG_AE]    = (cnt != 0) && (cnt <= ae);
    f[FLG_AF]    = !f[FLG_FULL] && (cnt >= af);
    f[FLG_PAUSA] = f[FLG_AF] | f[FLG_FULL];
    return f;
  endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
// Storage is not reset; only the read register is.
module fifo_ram_2p #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // rdata holds its last value when no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_param.sv
// Parameterized synchronous FIFO with occupancy flags and error reporting.
// Define FIFO_PARAM_ERR_STICKY_EN to make err_overflow/err_underflow latch until reset.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   af_th,
  input  logic [ADDR_WIDTH:0]   ae_th,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  pausa,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  fifo_req_t             req;
  logic                  push_ok, pop_ok;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic [FLG_W-1:0]      flags;
  logic [ERR_W-1:0]      err_set, err_q;
  logic [RD_STAGES:0]    vld_pipe;

  assign req = '{push: push, pop: pop};

  assign flags = flag_decode(32'(count_q), DEPTH, 32'(af_th), 32'(ae_th));

  assign fifo_empty   = flags[FLG_EMPTY];
  assign fifo_full    = flags[FLG_FULL];
  assign almost_empty = flags[FLG_AE];
  assign almost_full  = flags[FLG_AF];
  assign pausa        = flags[FLG_PAUSA];
  assign count        = count_q;

  // Pop on empty is rejected even with a concurrent push: no fall-through.
  assign push_ok = req.push && !fifo_full;
  assign pop_ok  = req.pop  && !fifo_empty;

  always_comb begin
    err_set          = '0;
    err_set[ERR_OVF] = req.push && fifo_full;
    err_set[ERR_UNF] = req.pop  && fifo_empty;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (ADDR_WIDTH+1)'(1);
        2'b01:   count_q <= count_q - (ADDR_WIDTH+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      err_q <= '0;
    end else begin
`ifdef FIFO_PARAM_ERR_STICKY_EN
      err_q <= err_q | err_set;
`else
      err_q <= err_set;
`endif
    end
  end

  assign err_overflow  = err_q[ERR_OVF];
  assign err_underflow = err_q[ERR_UNF];

  // Valid tracks the RAM read latency; extra stages only if RD_STAGES grows.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= pop_ok;
      for (int i = 1; i <= RD_STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign data_valid = vld_pipe[RD_STAGES];

  fifo_ram_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (reset_L),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (pop_ok),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param (DATA_WIDTH=6, depth 4) with hand-computed expectations.
module tb_fifo_param;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       push, pop;
  logic [5:0] data_in;
  logic [2:0] af_th, ae_th;
  logic [5:0] data_out;
  logic       data_valid;
  logic [2:0] count;
  logic       fifo_empty, fifo_full, almost_empty, almost_full, pausa;
  logic       err_overflow, err_underflow;

  int checks = 0;
  int errors = 0;

`ifdef FIFO_PARAM_ERR_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  fifo_param #(.DATA_WIDTH(6), .ADDR_WIDTH(2)) dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .push          (push),
    .pop           (pop),
    .data_in       (data_in),
    .af_th         (af_th),
    .ae_th         (ae_th),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .count         (count),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .almost_empty  (almost_empty),
    .almost_full   (almost_full),
    .pausa         (pausa),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [2:0] c, input logic e,
                           input logic f, input logic ae, input logic af, input logic pa);
    chk({tag, " count"}, 32'(count), 32'(c));
    chk({tag, " empty"}, 32'(fifo_empty), 32'(e));
    chk({tag, " full"},  32'(fifo_full), 32'(f));
    chk({tag, " ae"},    32'(almost_empty), 32'(ae));
    chk({tag, " af"},    32'(almost_full), 32'(af));
    chk({tag, " pausa"}, 32'(pausa), 32'(pa));
  endtask

  initial begin
    reset_L = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
    af_th = 3'd3; ae_th = 3'd1;
    tick(); tick();
    chk_state("rst", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst dout", 32'(data_out), 32'h0);
    chk("rst dv", 32'(data_valid), 32'h0);
    chk("rst ovf", 32'(err_overflow), 32'h0);
    chk("rst unf", 32'(err_underflow), 32'h0);
    reset_L = 1'b1;

    // Fill: almost_full only after the 3rd push, full after the 4th.
    push = 1'b1; data_in = 6'h01; tick();
    chk_state("push1", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    data_in = 6'h02; tick();
    chk_state("push2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    data_in = 6'h03; tick();
    chk_state("push3", 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    data_in = 6'h04; tick();
    chk_state("push4", 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Overflow attempt.
    data_in = 6'h3F; tick();
    chk("ovf pulse", 32'(err_overflow), 32'h1);
    chk("ovf count", 32'(count), 32'd4);
    push = 1'b0; tick();
    chk("ovf after", 32'(err_overflow), 32'(STICKY));
    chk("ovf count2", 32'(count), 32'd4);

    // Drain in order.
    pop = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("pop%0d data", i), 32'(data_out), 32'(i));
      chk($sformatf("pop%0d dv", i), 32'(data_valid), 32'h1);
      chk($sformatf("pop%0d count", i), 32'(count), 32'(4 - i));
    end
    pop = 1'b0; tick();
    chk_state("drained", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle dv", 32'(data_valid), 32'h0);
    chk("idle hold", 32'(data_out), 32'h04);

    // Underflow attempt.
    pop = 1'b1; tick();
    chk("unf pulse", 32'(err_underflow), 32'h1);
    chk("unf dv", 32'(data_valid), 32'h0);
    chk("unf count", 32'(count), 32'd0);
    pop = 1'b0; tick();
    chk("unf after", 32'(err_underflow), 32'(STICKY));
    chk("unf dv2", 32'(data_valid), 32'h0);

    // Steady state at count=2 with simultaneous push/pop; pointers wrap.
    push = 1'b1; data_in = 6'h10; tick();
    data_in = 6'h11; tick();
    chk("pre sim count", 32'(count), 32'd2);
    pop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = 6'(8'h12 + i);
      tick();
      chk($sformatf("sim%0d data", i), 32'(data_out), 32'(8'h10 + i));
      chk($sformatf("sim%0d count", i), 32'(count), 32'd2);
    end
    push = 1'b0;
    tick();
    chk("tail1", 32'(data_out), 32'h1A);
    tick();
    chk("tail2", 32'(data_out), 32'h1B);
    chk("tail empty", 32'(fifo_empty), 32'h1);

    // Push and pop on empty: only the push is taken.
    push = 1'b1; pop = 1'b1; data_in = 6'h2A; tick();
    chk("empty both count", 32'(count), 32'd1);
    chk("empty both dv", 32'(data_valid), 32'h0);
    push = 1'b0; pop = 1'b0;
    ae_th = 3'd0; #1;
    chk("ae_th0", 32'(almost_empty), 32'h0);
    ae_th = 3'd1; #1;
    chk("ae_th1", 32'(almost_empty), 32'h1);

    // Fill, then push and pop on full: only the pop is taken.
    push = 1'b1;
    data_in = 6'h2B; tick();
    data_in = 6'h2C; tick();
    data_in = 6'h2D; tick();
    chk("refill full", 32'(fifo_full), 32'h1);
    pop = 1'b1; data_in = 6'h2E; tick();
    chk("full both count", 32'(count), 32'd3);
    chk("full both data", 32'(data_out), 32'h2A);
    chk("full both dv", 32'(data_valid), 32'h1);
    af_th = 3'd5; #1;
    chk("af_th5 af", 32'(almost_full), 32'h0);
    chk("af_th5 pausa", 32'(pausa), 32'h0);
    af_th = 3'd3; #1;
    chk("af_th3 af", 32'(almost_full), 32'h1);

    // Asynchronous reset mid-burst at count=3.
    pop = 1'b0; push = 1'b1; data_in = 6'h30;
    reset_L = 1'b0; #1;
    chk_state("async rst", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("async dout", 32'(data_out), 32'h0);
    chk("async dv", 32'(data_valid), 32'h0);
    chk("async ovf", 32'(err_overflow), 32'h0);
    chk("async unf", 32'(err_underflow), 32'h0);
    push = 1'b0;
    tick();
    reset_L = 1'b1;
    tick();
    chk("post rst empty", 32'(fifo_empty), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 6, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 2; depth DEPTH = 2**ADDR_WIDTH entries.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port reset_L, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port push, input, 1, write request.
REQ-006 SHALL have port pop, input, 1, read request.
REQ-007 SHALL have port data_in, input, DATA_WIDTH, write data.
REQ-008 SHALL have port af_th, input, ADDR_WIDTH+1, almost-full threshold, quasi-static.
REQ-009 SHALL have port ae_th, input, ADDR_WIDTH+1, almost-empty threshold, quasi-static.
REQ-010 SHALL have port data_out, output, DATA_WIDTH, registered read data.
REQ-011 SHALL have port data_valid, output, 1, data_out holds a popped word this cycle.
REQ-012 SHALL have port count, output, ADDR_WIDTH+1, current occupancy, 0..DEPTH.
REQ-013 SHALL have outputs fifo_empty, fifo_full, almost_empty, almost_full, pausa, each 1 bit.
REQ-014 SHALL have outputs err_overflow and err_underflow, each 1 bit.

Function
REQ-015 SHALL accept a push iff push=1 and fifo_full=0; the word is written at wr_ptr and wr_ptr increments.
REQ-016 SHALL accept a pop iff pop=1 and fifo_empty=0; the word at rd_ptr is read and rd_ptr increments.
REQ-017 SHALL present a popped word on data_out with data_valid=1 exactly one cycle after the accepted pop; data_valid=0 otherwise, and data_out holds its last value.
REQ-018 SHALL wrap pointers modulo DEPTH with no gap or skipped entry.
REQ-019 SHALL update count by +1 on push only, -1 on pop only, and 0 on both or neither.
REQ-020 On push and pop together while neither empty nor full, SHALL accept both; while empty, SHALL accept only the push, with no fall-through; while full, SHALL accept only the pop.
REQ-021 SHALL decode flags combinationally from the count register: fifo_empty = (count==0); fifo_full = (count==DEPTH); almost_empty = (count!=0 && count<=ae_th); almost_full = (!fifo_full && count>=af_th); pausa = almost_full | fifo_full.
REQ-022 SHALL pulse err_overflow for one cycle, one cycle after a push is rejected for full; no state changes.
REQ-023 SHALL pulse err_underflow for one cycle, one cycle after a pop is rejected for empty; no state changes.
REQ-024 SHALL treat af_th > DEPTH as never almost-full, and ae_th = 0 as never almost-empty.

Reset
REQ-025 While reset_L=0, SHALL hold wr_ptr=0, rd_ptr=0, count=0, data_out=0, data_valid=0, err_overflow=0 and err_underflow=0; consequently fifo_empty=1 and all other flags are 0.
REQ-026 Reset mid-operation SHALL discard all stored entries; memory contents need not be cleared.

Configuration
REQ-027 With FIFO_PARAM_ERR_STICKY_EN defined, err_overflow and err_underflow SHALL latch at 1 until reset_L=0; without it, they SHALL behave as single-cycle pulses per REQ-022 and REQ-023.

Structure
REQ-028 SHALL take flag-decode helper constants and the error-bit index typedef from shared package fifo_pkg.
REQ-029 SHALL instantiate one sub-module, fifo_ram_2p: DATA_WIDTH x DEPTH, one write port, one registered read port, clocked by clk.

Verification
REQ-030 Reset, then 4 pushes of 0x01..0x04 with af_th=3 -> count=4, fifo_full=1, pausa=1; almost_full=1 only after the 3rd push.
REQ-031 Full FIFO plus one push of 0x3F -> err_overflow pulses 1 cycle later; count stays 4; 0x3F is never read out.
REQ-032 4 pops -> data_out returns 0x01..0x04 in order, each 1 cycle after its pop, with data_valid=1; then fifo_empty=1.
REQ-033 Pop on empty -> err_underflow=1 (pulse, or sticky under FIFO_PARAM_ERR_STICKY_EN); data_valid stays 0.
REQ-034 Count=2 with simultaneous push and pop for 10 cycles -> count stays 2; pointers wrap; data order is preserved.
REQ-035 reset_L driven low asynchronously mid-burst at count=3 -> all outputs reach reset values before the next clk edge.
